branch_pred_ctrl: RTL and testbench

Branch prediction and control-flow redirect controller for the five-stage pipelined CPU. It sits beside the IF stage. It predicts next-PC for branches and jumps using a small direct-mapped branch target buffer (BTB). It resolves predictions against EX-stage outcomes and drives the PC redirect and the IF/ID and ID/EX flush controls for every strategy code. It also keeps branch and mispredict statistics.

---
 rtl/cpu_pipe_pkg.sv | 30 +++
 rtl/btb_array.sv | 74 +++++++
 rtl/branch_pred_ctrl.sv | 128 ++++++++++++
 tb/tb_branch_pred_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: branch strategy codes, 2-bit saturating counters
// and the BTB entry layout used by the branch predictor.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        STRAT_NT    = 2'b00,
        STRAT_TAKEN = 2'b01,
        STRAT_DELAY = 2'b10,
        STRAT_DYN   = 2'b11
    } strategy_e;

    typedef logic [1:0] ctr2_t;

    function automatic ctr2_t ctr_inc(input ctr2_t c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic ctr2_t ctr_dec(input ctr2_t c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Tag holds pc >> (IDX+2) zero-extended, so the layout is depth-independent.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr2_t       ctr;
    } btb_entry_t;

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one combinational read port, one synchronous
// read-modify-write update port and a clear-all of the valid bits.
module btb_array
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned IDX      = 4,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clr,
    input  logic [IDX-1:0] i_rd_idx,
    output btb_entry_t     o_rd_entry,
    input  logic           i_upd_en,
    input  logic [IDX-1:0] i_upd_idx,
    input  logic [31:0]    i_upd_tag,
    input  logic [31:0]    i_upd_target,
    input  logic           i_upd_taken,
    input  logic           i_upd_jump
);

    btb_entry_t r_mem [ENTRIES];
    btb_entry_t w_old;
    btb_entry_t w_new;
    logic       w_hit;
    logic       w_we;

    assign o_rd_entry = r_mem[i_rd_idx];

    always_comb begin
        w_old = r_mem[i_upd_idx];
        w_hit = w_old.valid && (w_old.tag == i_upd_tag);
        w_new = w_old;
        w_we  = 1'b0;
        if (i_upd_en) begin
            if (i_upd_taken) begin
                w_we         = 1'b1;
                w_new.valid  = 1'b1;
                w_new.tag    = i_upd_tag;
                w_new.target = i_upd_target;
                if (i_upd_jump) begin
                    w_new.ctr = 2'b11;
                end else if (w_hit) begin
                    w_new.ctr = ctr_inc(w_old.ctr);
                end else begin
                    w_new.ctr = CTR_INIT + 2'd1;
                end
            end else if (w_hit) begin
                w_we      = 1'b1;
                w_new.ctr = ctr_dec(w_old.ctr);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};
            end
        end else begin
            if (w_we) begin
                r_mem[i_upd_idx] <= w_new;
            end
            // A strategy change invalidates everything, including a same-edge write.
            if (i_clr) begin
                for (int unsigned i = 0; i < ENTRIES; i++) begin
                    r_mem[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor beside IF: BTB lookup, EX-stage resolution with redirect
// and flush generation per strategy, and branch/mispredict statistics.
module branch_pred_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  strategy,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_jump,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
);

    localparam int unsigned IDX = $clog2(BTB_ENTRIES);

    strategy_e  w_strat;
    btb_entry_t w_rd;
    logic       w_hit;
    logic       w_taken;
    logic       w_mispred;
    logic       w_clr;
    logic [1:0] r_strat;
    logic       r_strat_vld;
    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispred_cnt;

    assign w_strat   = strategy_e'(strategy);
    assign w_hit     = w_rd.valid && (w_rd.tag == (if_pc >> (IDX + 2)));
    assign w_taken   = ex_taken || ex_is_jump;
    assign w_mispred = (w_taken != ex_pred_taken) ||
                       (w_taken && (ex_pred_target != ex_target));
    // r_strat_vld stands in for "registered strategy = input" during reset.
    assign w_clr     = r_strat_vld && (r_strat != strategy);

    btb_array #(
        .ENTRIES  (BTB_ENTRIES),
        .IDX      (IDX),
        .CTR_INIT (CTR_INIT)
    ) u_btb (
        .i_clk        (clk),
        .i_rst_n      (rst),
        .i_clr        (w_clr),
        .i_rd_idx     (if_pc[IDX+1:2]),
        .o_rd_entry   (w_rd),
        .i_upd_en     (ex_valid),
        .i_upd_idx    (ex_pc[IDX+1:2]),
        .i_upd_tag    (ex_pc >> (IDX + 2)),
        .i_upd_target (ex_target),
        .i_upd_taken  (w_taken),
        .i_upd_jump   (ex_is_jump)
    );

    always_comb begin
        pred_taken     = 1'b0;
        pred_target    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;
        if (rst) begin
            if (ex_valid) begin
                case (w_strat)
                    STRAT_NT, STRAT_DELAY: begin
                        redirect_valid = w_taken;
                        redirect_pc    = w_taken ? ex_target : '0;
                        flush_ifid     = w_taken;
                        flush_idex     = w_taken && (w_strat == STRAT_NT);
                    end
                    STRAT_TAKEN, STRAT_DYN: begin
                        redirect_valid = w_mispred;
                        if (w_mispred) begin
                            redirect_pc = w_taken ? ex_target : ex_pc + 32'd4;
                        end
                        flush_ifid = w_mispred;
                        flush_idex = w_mispred;
                    end
                endcase
            end
            case (w_strat)
                STRAT_TAKEN: pred_taken = w_hit;
                STRAT_DYN:   pred_taken = w_hit && (w_rd.ctr >= 2'b10);
                default:     pred_taken = 1'b0;
            endcase
            if (redirect_valid) begin
                pred_taken = 1'b0;
            end
            pred_target = w_hit ? w_rd.target : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_strat       <= '0;
            r_strat_vld   <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_strat     <= strategy;
            r_strat_vld <= 1'b1;
            if (ex_valid && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + 16'd1;
            end
            if (redirect_valid && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 16'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed scenarios plus random
// traffic against a behavioural BTB/statistics model.
module tb_branch_pred_ctrl;

    localparam int N = 16;
    localparam int CTR_INIT_M = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  strategy;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_jump;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic        flush_idex;
    logic [15:0] branch_cnt;
    logic [15:0] mispred_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl #(
        .BTB_ENTRIES (16),
        .CTR_INIT    (2'b01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .strategy       (strategy),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_jump     (ex_is_jump),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .branch_cnt     (branch_cnt),
        .mispred_cnt    (mispred_cnt)
    );

    // ---------------- reference model ----------------
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    int unsigned m_bcnt;
    int unsigned m_mcnt;
    logic [1:0]  m_strat;

    logic        e_pt, e_rv, e_fi, e_fx;
    logic [31:0] e_ptg, e_rpc;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc / 4) % N;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = CTR_INIT_M;
        end
        m_bcnt  = 0;
        m_mcnt  = 0;
        m_strat = strategy;
    endfunction

    function automatic void model_eval();
        int unsigned i;
        bit hit, tk, mis;
        e_pt = 0; e_ptg = 0; e_rv = 0; e_rpc = 0; e_fi = 0; e_fx = 0;
        if (rst !== 1'b1) return;
        i   = idx_of(if_pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(if_pc));
        tk  = ex_taken || ex_is_jump;
        if (ex_valid) begin
            if (strategy == 2'b00 || strategy == 2'b10) begin
                if (tk) begin
                    e_rv = 1; e_rpc = ex_target; e_fi = 1; e_fx = (strategy == 2'b00);
                end
            end else begin
                mis = (tk != ex_pred_taken) || (tk && ex_pred_target != ex_target);
                if (mis) begin
                    e_rv = 1; e_rpc = tk ? ex_target : ex_pc + 4; e_fi = 1; e_fx = 1;
                end
            end
        end
        if (hit) e_ptg = m_target[i];
        if (!e_rv) begin
            if (strategy == 2'b01)      e_pt = hit;
            else if (strategy == 2'b11) e_pt = hit && (m_ctr[i] >= 2);
        end
    endfunction

    function automatic void model_commit();
        int unsigned i;
        bit hit;
        model_eval();
        if (rst !== 1'b1) begin
            model_reset();
            return;
        end
        if (ex_valid) begin
            if (m_bcnt < 65535) m_bcnt++;
            i   = idx_of(ex_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
            if (ex_taken || ex_is_jump) begin
                if (ex_is_jump)  m_ctr[i] = 3;
                else if (hit)    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else             m_ctr[i] = CTR_INIT_M + 1;
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = ex_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end
        if (e_rv && m_mcnt < 65535) m_mcnt++;
        if (strategy != m_strat) begin
            for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
        end
        m_strat = strategy;
    endfunction

    function automatic logic [67:0] obs_vec();
        return {pred_taken, pred_target, redirect_valid, (e_rv ? redirect_pc : 32'h0),
                flush_ifid, flush_idex};
    endfunction

    function automatic logic [67:0] exp_vec();
        return {e_pt, e_ptg, e_rv, e_rpc, e_fi, e_fx};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic j, input logic t,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt);
        ex_valid = v; ex_is_jump = j; ex_taken = t; ex_pc = pc;
        ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic idle_ex();
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; strategy = 2'b01; if_pc = 32'h0;
        idle_ex();
        model_reset();
        tick();
        tick();
        model_eval();
        total++;
        if (obs_vec() !== 68'h0 || redirect_pc !== 32'h0) begin
            bad++; $display("FAIL reset_outputs: got %h rpc %h want 0", obs_vec(), redirect_pc);
        end
        total++;
        if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_counts: got %h/%h want 0/0", branch_cnt, mispred_cnt);
        end
        rst = 1'b1;
        set_ex(1, 1, 1, 32'd100, 32'd200, 0, 32'h0);
        if_pc = 32'd100;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL alloc_jump: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || pred_target !== 32'd200) begin
            bad++; $display("FAIL pre_reset_hit: got %h want %h", obs_vec(), exp_vec());
        end
        rst = 1'b0;
        #1; model_eval();
        total++;
        if (obs_vec() !== 68'h0 || redirect_pc !== 32'h0 || pred_target !== 32'h0) begin
            bad++; $display("FAIL reset_midres: got %h rpc %h want 0", obs_vec(), redirect_pc);
        end
        total++;
        if (branch_cnt !== 16'h0 || mispred_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_midres_cnt: got %h/%h want 0/0", branch_cnt, mispred_cnt);
        end
        tick();
        rst = 1'b1;
        idle_ex();
        #2; model_eval();
        total++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_miss: got pt %b tgt %h want 0 0", pred_taken, pred_target);
        end
        tick();
    endtask

    task automatic test_not_taken();
        int unsigned mc;
        strategy = 2'b00;
        idle_ex();
        tick();
        mc = mispred_cnt;
        set_ex(1, 0, 1, 32'd20, 32'd88, 0, 32'h0);
        if_pc = 32'd8;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || redirect_pc !== 32'd88 || !flush_ifid || !flush_idex) begin
            bad++; $display("FAIL nt_redirect: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        idle_ex();
        if_pc = 32'd20;
        #2; model_eval();
        total++;
        if (pred_taken !== 1'b0 || obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL nt_no_pred: got %h want %h", obs_vec(), exp_vec());
        end
        total++;
        if (mispred_cnt !== 16'(mc + 1) || mispred_cnt !== m_mcnt[15:0]) begin
            bad++; $display("FAIL nt_mispred_cnt: got %0d want %0d", mispred_cnt, mc + 1);
        end
        tick();
    endtask

    task automatic test_static_jump();
        strategy = 2'b01;
        idle_ex();
        tick();
        set_ex(1, 1, 0, 32'd76, 32'd24, 0, 32'h0);
        if_pc = 32'd4;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || redirect_pc !== 32'd24) begin
            bad++; $display("FAIL st_first: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        idle_ex();
        if_pc = 32'd76;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || pred_taken !== 1'b1 || pred_target !== 32'd24) begin
            bad++; $display("FAIL st_predict: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        set_ex(1, 1, 0, 32'd76, 32'd24, 1, 32'd24);
        if_pc = 32'd24;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || redirect_valid || flush_ifid || flush_idex) begin
            bad++; $display("FAIL st_correct: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_dynamic();
        logic [3:0] exp_pt;
        strategy = 2'b11;
        idle_ex();
        tick();
        set_ex(1, 0, 1, 32'd60, 32'd100, 0, 32'h0);
        tick();
        set_ex(1, 0, 1, 32'd60, 32'd100, 1, 32'd100);
        tick();
        exp_pt = 4'b1100;
        for (int step = 0; step < 3; step++) begin
            idle_ex();
            if_pc = 32'd60;
            #2; model_eval();
            total++;
            if (obs_vec() !== exp_vec() || pred_taken !== exp_pt[3 - step]) begin
                bad++; $display("FAIL dyn_pred_%0d: got %h want %h", step, obs_vec(), exp_vec());
            end
            tick();
            if (step < 2) begin
                set_ex(1, 0, 0, 32'd60, 32'd100, 1, 32'd100);
                if_pc = 32'd64;
                #2; model_eval();
                total++;
                if (obs_vec() !== exp_vec() || redirect_pc !== 32'd64) begin
                    bad++; $display("FAIL dyn_nt_%0d: got %h want %h", step, obs_vec(), exp_vec());
                end
                tick();
            end
        end
    endtask

    task automatic test_delay_slot();
        strategy = 2'b10;
        idle_ex();
        tick();
        set_ex(1, 0, 1, 32'd28, 32'd80, 0, 32'h0);
        if_pc = 32'd36;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || !flush_ifid || flush_idex || redirect_pc !== 32'd80) begin
            bad++; $display("FAIL delay_slot: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pc;
        bit chg;
        for (int c = 0; c < 400; c++) begin
            chg = ($urandom % 40) == 0;
            if (chg) strategy = 2'($urandom);
            if_pc = (($urandom % 3) * 64) + (($urandom % 6) * 4);
            pc    = (($urandom % 3) * 64) + (($urandom % 6) * 4);
            set_ex(!chg && ($urandom % 3 != 0), ($urandom % 5) == 0, $urandom % 2, pc,
                   (($urandom % 4) * 4) + 32'h200, $urandom % 2,
                   ($urandom % 2) ? m_target[idx_of(pc)] : (($urandom % 4) * 4) + 32'h200);
            #2; model_eval();
            total++;
            if (obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL rand_out c%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
            total++;
            if (branch_cnt !== m_bcnt[15:0] || mispred_cnt !== m_mcnt[15:0]) begin
                bad++; $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d",
                                c, branch_cnt, mispred_cnt, m_bcnt, m_mcnt);
            end
            tick();
        end
        idle_ex();
    endtask

    task automatic test_saturation();
        strategy = 2'b00;
        idle_ex();
        tick();
        set_ex(1, 0, 1, 32'd20, 32'd88, 0, 32'h0);
        for (int c = 0; c < 65540; c++) tick();
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || !redirect_valid) begin
            bad++; $display("FAIL sat_redirect: got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        total++;
        if (mispred_cnt !== 16'hFFFF || branch_cnt !== 16'hFFFF || mispred_cnt !== m_mcnt[15:0]) begin
            bad++; $display("FAIL sat_cnt: got %h/%h want ffff/ffff", branch_cnt, mispred_cnt);
        end
        strategy = 2'b01;
        idle_ex();
        tick();
        for (int k = 0; k < 8; k++) begin
            set_ex(1, 1, 1, 32'h400 + k * 4, 32'h1000 + k * 8, 0, 32'h0);
            tick();
        end
        idle_ex();
        if_pc = 32'h408;
        #2; model_eval();
        total++;
        if (obs_vec() !== exp_vec() || pred_target !== 32'h1010) begin
            bad++; $display("FAIL chg_before: got %h want %h", obs_vec(), exp_vec());
        end
        strategy = 2'b11;
        tick();
        for (int k = 0; k < 8; k++) begin
            if_pc = 32'h400 + k * 4;
            #1; model_eval();
            total++;
            if (pred_taken !== 1'b0 || pred_target !== 32'h0 || obs_vec() !== exp_vec()) begin
                bad++; $display("FAIL chg_miss_%0d: got pt %b tgt %h want 0 0", k, pred_taken, pred_target);
            end
        end
        total++;
        if (mispred_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL chg_keeps_stats: got %h want ffff", mispred_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_not_taken();
        test_static_jump();
        test_dynamic();
        test_delay_slot();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
